// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: shared constants, pointer compares and parameter checks for the BRAM FIFO core
package bram_fifo_pkg;
    localparam int MAX_BRAM_LATENCY = 2;
    localparam int PTR_MAX_W = 32;

    function automatic logic is_empty(input logic [PTR_MAX_W-1:0] wr_ptr, input logic [PTR_MAX_W-1:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

    // Low address bits equal and wrap flags differ; callers zero-extend narrower pointers.
    function automatic logic is_full(input logic [PTR_MAX_W-1:0] wr_ptr, input logic [PTR_MAX_W-1:0] rd_ptr,
                                     input int addr_width);
        return (wr_ptr ^ rd_ptr) == (PTR_MAX_W'(1) << addr_width);
    endfunction

    function automatic logic params_ok(input int bram_latency, input int addr_width, input int afull_level);
        return bram_latency >= 1 && bram_latency <= MAX_BRAM_LATENCY && afull_level <= (1 << addr_width);
    endfunction
endpackage

// File: rtl/bram_fifo_out_buf.sv
// bram_fifo_out_buf: small register FIFO that absorbs BRAM read returns and drives the stream
module bram_fifo_out_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pop;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    // The issue logic upstream guarantees a return never lands on a full buffer without a pop.
    always_comb begin
        pop     = out_valid && out_ready;
        head_d  = pop ? nxt(head_q) : head_q;
        tail_d  = in_valid ? nxt(tail_q) : tail_q;
        count_d = count_q + CW'(in_valid) - CW'(pop);
        mem_d   = mem_q;
        if (in_valid) mem_d[tail_q] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign out_valid = count_q != '0;
    assign out_data  = mem_q[head_q];
    assign count     = count_q;
endmodule

// File: rtl/bram_fifo_stream_core.sv
// bram_fifo_stream_core: BRAM pointer engine with read prefetch onto an AXI4-Stream master
module bram_fifo_stream_core
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BRAM_LATENCY = 1,
    parameter int AFULL_LEVEL  = 1020
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow
);
    localparam int OB_DEPTH = BRAM_LATENCY + 1;
    localparam int OCW      = $clog2(OB_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AFULL_COUNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    if (!params_ok(BRAM_LATENCY, ADDR_WIDTH, AFULL_LEVEL)) begin : g_param_check
        $error("bram_fifo_stream_core: BRAM_LATENCY must be 1 or 2 and AFULL_LEVEL <= depth");
    end

    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [BRAM_LATENCY-1:0] tag_q, tag_d;
    logic                    overflow_q, overflow_d;
    logic                    flush, push, pop, issue;
    logic [OCW-1:0]          ob_count;

    // A pop frees its output slot on the same edge, so it is credited to keep one word per cycle.
    always_comb begin
        flush        = reset || clear;
        full         = count_q == FULL_COUNT;
        wr_ready     = !full && !flush;
        push         = wr_valid && wr_ready;
        pop          = m_axis_tvalid && m_axis_tready;
        issue        = !flush && !is_empty(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q))
                       && ($countones(tag_q) + int'(ob_count) < OB_DEPTH + int'(pop));
        wr_ptr_d     = wr_ptr_q + (ADDR_WIDTH+1)'(push);
        rd_ptr_d     = rd_ptr_q + (ADDR_WIDTH+1)'(issue);
        count_d      = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        overflow_d   = overflow_q || (wr_valid && !wr_ready);
        tag_d        = BRAM_LATENCY'({tag_q, issue});
        empty        = count_q == '0;
        almost_full  = count_q >= AFULL_COUNT;
        overflow     = overflow_q;
        count        = count_q;
        bram_wr_en   = push;
        bram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
        bram_wr_data = wr_data;
        bram_rd_en   = issue;
        bram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    end

    // Zeroing the tags on flush drops any BRAM returns still in flight.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tag_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tag_q      <= tag_d;
            overflow_q <= overflow_d;
        end
    end

    bram_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OB_DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (flush),
        .in_data   (bram_rd_data),
        .in_valid  (tag_q[BRAM_LATENCY-1]),
        .out_data  (m_axis_tdata),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .count     (ob_count)
    );
endmodule
